// File: rtl/match_pkg.sv
// Shared encodings for the match sequencer: FSM states, game_state codes and score width.
package match_pkg;

  localparam int SCORE_W = 4;

  localparam logic [2:0] ST_IDLE        = 3'd0;
  localparam logic [2:0] ST_COUNTDOWN   = 3'd1;
  localparam logic [2:0] ST_PLAY        = 3'd2;
  localparam logic [2:0] ST_POINT_PAUSE = 3'd3;
  localparam logic [2:0] ST_GAME_OVER   = 3'd4;
  localparam logic [2:0] ST_PAUSED      = 3'd5;

  localparam logic [1:0] GS_IDLE   = 2'b00;
  localparam logic [1:0] GS_RUN    = 2'b01;
  localparam logic [1:0] GS_P1_WIN = 2'b10;
  localparam logic [1:0] GS_P2_WIN = 2'b11;

endpackage

// File: rtl/match_sequencer_btn_sync_edge.sv
// Two-flop synchronizer for an active-low key plus a one-cycle pulse on its falling edge.
// RESET_LEVEL is the key's idle level, so releasing reset never produces a press.
module btn_sync_edge #(
  parameter logic RESET_LEVEL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n,
  output logic press
);

  logic sync_1, sync_2, sync_3;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_1 <= RESET_LEVEL;
      sync_2 <= RESET_LEVEL;
      sync_3 <= RESET_LEVEL;
    end else begin
      sync_1 <= btn_n;
      sync_2 <= sync_1;
      sync_3 <= sync_2;
    end
  end

  assign press = sync_3 & ~sync_2;

endmodule

// File: rtl/match_sequencer.sv
// Match-level FSM: serve countdown, rally, post-point pause, game over; owns the scores.
// Build with MATCH_PAUSE_EN to add a start-key pause during a rally.
//   state          | meaning
//   ST_IDLE        | waiting for start
//   ST_COUNTDOWN   | serve countdown, seconds shown on countdown
//   ST_PLAY        | rally in progress, ball enabled
//   ST_POINT_PAUSE | pause after a point, then re-serve
//   ST_GAME_OVER   | winner shown, scores frozen
//   ST_PAUSED      | rally halted by start key (MATCH_PAUSE_EN only)
module match_sequencer
  import match_pkg::*;
#(
  parameter int WIN_SCORE  = 7,
  parameter int COUNT_SECS = 3,
  parameter int PAUSE_MS   = 1000,
  parameter int MS_PER_SEC = 1000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clk_1ms,
  input  logic               start_n,
  input  logic               p1_point,
  input  logic               p2_point,
  output logic [1:0]         game_state,
  output logic [SCORE_W-1:0] p1_score,
  output logic [SCORE_W-1:0] p2_score,
  output logic               ball_enable,
  output logic               ball_serve,
  output logic               serve_dir,
  output logic [1:0]         countdown
);

  localparam int MS_W = (MS_PER_SEC > 1) ? $clog2(MS_PER_SEC) : 1;
  localparam logic [MS_W-1:0]    MS_RELOAD    = MS_W'(MS_PER_SEC - 1);
  localparam logic [1:0]         SEC_RELOAD   = 2'(COUNT_SECS);
  localparam logic [11:0]        PAUSE_RELOAD = 12'(PAUSE_MS);
  localparam logic [SCORE_W-1:0] WIN          = SCORE_W'(WIN_SCORE);

  logic [2:0]         state;
  logic [1:0]         sec;
  logic [MS_W-1:0]    ms_cnt;
  logic [11:0]        pause_cnt;
  logic               clk_1ms_q;
  logic               ms_tick;
  logic               press;
  logic [SCORE_W-1:0] p1_next, p2_next;

  btn_sync_edge #(.RESET_LEVEL(1'b1)) u_start_sync (
    .clk   (clk),
    .reset (reset),
    .btn_n (start_n),
    .press (press)
  );

  // clk_1ms is plain data here; its rising edge becomes a one-clk tick.
  always_ff @(posedge clk) begin
    if (reset) clk_1ms_q <= 1'b1;
    else       clk_1ms_q <= clk_1ms;
  end

  assign ms_tick = clk_1ms & ~clk_1ms_q;
  assign p1_next = p1_score + SCORE_W'(1);
  assign p2_next = p2_score + SCORE_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      game_state  <= GS_IDLE;
      p1_score    <= '0;
      p2_score    <= '0;
      ball_enable <= 1'b0;
      ball_serve  <= 1'b0;
      serve_dir   <= 1'b0;
      countdown   <= 2'd0;
      sec         <= 2'd0;
      ms_cnt      <= '0;
      pause_cnt   <= '0;
    end else begin
      ball_serve <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (press) begin
            state      <= ST_COUNTDOWN;
            game_state <= GS_RUN;
            sec        <= SEC_RELOAD;
            ms_cnt     <= MS_RELOAD;
            countdown  <= SEC_RELOAD;
          end
        end
        ST_COUNTDOWN: begin
          if (ms_tick) begin
            if (ms_cnt == '0) begin
              ms_cnt    <= MS_RELOAD;
              sec       <= sec - 2'd1;
              countdown <= sec - 2'd1;
              if (sec == 2'd1) begin
                state      <= ST_PLAY;
                ball_serve <= 1'b1;
              end
            end else begin
              ms_cnt <= ms_cnt - MS_W'(1);
            end
          end
        end
        ST_PLAY: begin
          // p1 has priority when both players score in the same cycle.
          if (p1_point) begin
            p1_score    <= p1_next;
            serve_dir   <= 1'b1;
            ball_enable <= 1'b0;
            if (p1_next == WIN) begin
              state      <= ST_GAME_OVER;
              game_state <= GS_P1_WIN;
            end else begin
              state     <= ST_POINT_PAUSE;
              pause_cnt <= PAUSE_RELOAD;
            end
          end else if (p2_point) begin
            p2_score    <= p2_next;
            serve_dir   <= 1'b0;
            ball_enable <= 1'b0;
            if (p2_next == WIN) begin
              state      <= ST_GAME_OVER;
              game_state <= GS_P2_WIN;
            end else begin
              state     <= ST_POINT_PAUSE;
              pause_cnt <= PAUSE_RELOAD;
            end
`ifdef MATCH_PAUSE_EN
          end else if (press) begin
            state       <= ST_PAUSED;
            ball_enable <= 1'b0;
`endif
          end else begin
            ball_enable <= 1'b1;
          end
        end
        ST_POINT_PAUSE: begin
          if (ms_tick) begin
            pause_cnt <= pause_cnt - 12'd1;
            if (pause_cnt <= 12'd1) begin
              state      <= ST_PLAY;
              ball_serve <= 1'b1;
            end
          end
        end
        ST_GAME_OVER: begin
          if (press) begin
            p1_score   <= '0;
            p2_score   <= '0;
            serve_dir  <= 1'b0;
            state      <= ST_COUNTDOWN;
            game_state <= GS_RUN;
            sec        <= SEC_RELOAD;
            ms_cnt     <= MS_RELOAD;
            countdown  <= SEC_RELOAD;
          end
        end
`ifdef MATCH_PAUSE_EN
        ST_PAUSED: begin
          if (press) state <= ST_PLAY;
        end
`endif
        default: begin
          state      <= ST_IDLE;
          game_state <= GS_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_match_sequencer.sv
// Directed match walk-through with randomized timing and point winners, checked against a score model.
module tb_match_sequencer;
  import match_pkg::*;

  localparam int WIN_SCORE  = 7;
  localparam int COUNT_SECS = 3;
  localparam int PAUSE_MS   = 1000;
  localparam int MS_PER_SEC = 1000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       clk_1ms = 1'b0;
  logic       start_n = 1'b1;
  logic       p1_point = 1'b0;
  logic       p2_point = 1'b0;
  logic [1:0] game_state;
  logic [3:0] p1_score, p2_score;
  logic       ball_enable, ball_serve, serve_dir;
  logic [1:0] countdown;

  int checks = 0;
  int errors = 0;
  int serve_count = 0;
  int m_p1 = 0, m_p2 = 0, m_dir = 0;
  logic [1:0] m_gs = GS_IDLE;
  int s0;

  match_sequencer #(
    .WIN_SCORE(WIN_SCORE), .COUNT_SECS(COUNT_SECS),
    .PAUSE_MS(PAUSE_MS), .MS_PER_SEC(MS_PER_SEC)
  ) dut (
    .clk(clk), .reset(reset), .clk_1ms(clk_1ms), .start_n(start_n),
    .p1_point(p1_point), .p2_point(p2_point), .game_state(game_state),
    .p1_score(p1_score), .p2_score(p2_score), .ball_enable(ball_enable),
    .ball_serve(ball_serve), .serve_dir(serve_dir), .countdown(countdown)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (ball_serve === 1'b1) serve_count++;
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic one_tick;
    @(negedge clk) clk_1ms = 1'b1;
    @(negedge clk) clk_1ms = 1'b0;
  endtask

  task automatic check_model(input string tag);
    check({tag, "_p1"}, p1_score, m_p1);
    check({tag, "_p2"}, p2_score, m_p2);
    check({tag, "_gs"}, game_state, m_gs);
  endtask

  task automatic press_key(input int gs_before);
    @(negedge clk) start_n = 1'b0;
    cyc(2);
    check("press_latency", game_state, gs_before);
    cyc(1);
  endtask

  task automatic release_key;
    start_n = 1'b1;
    cyc(3);
  endtask

  function automatic int exp_countdown(input int k);
    if (k >= COUNT_SECS * MS_PER_SEC) return 0;
    return COUNT_SECS - k / MS_PER_SEC;
  endfunction

  task automatic run_countdown;
    int base, total;
    base  = serve_count;
    total = COUNT_SECS * MS_PER_SEC;
    check("cd_start", countdown, COUNT_SECS);
    for (int k = 1; k <= total; k++) begin
      one_tick();
      if (k % MS_PER_SEC == 0 || k % MS_PER_SEC == MS_PER_SEC - 1) begin
        check("cd_value", countdown, exp_countdown(k));
        check("cd_serve_count", serve_count, base + ((k == total) ? 1 : 0));
        check("cd_ball_enable", ball_enable, 0);
      end
    end
    cyc(1);
    check("cd_enable_after", ball_enable, 1);
    check("cd_serve_single", serve_count, base + 1);
  endtask

  task automatic score_point(input bit do_p1, input bit do_p2);
    @(negedge clk) begin p1_point = do_p1; p2_point = do_p2; end
    @(negedge clk) begin p1_point = 1'b0; p2_point = 1'b0; end
    if (do_p1) begin
      m_p1++; m_dir = 1;
      if (m_p1 == WIN_SCORE) m_gs = GS_P1_WIN;
    end else if (do_p2) begin
      m_p2++; m_dir = 0;
      if (m_p2 == WIN_SCORE) m_gs = GS_P2_WIN;
    end
    check_model("point");
    check("point_dir", serve_dir, m_dir);
    check("point_enable", ball_enable, 0);
  endtask

  task automatic pulse_ignored(input string tag);
    @(negedge clk) begin p1_point = 1'($urandom_range(0, 1)); p2_point = 1'b1; end
    @(negedge clk) begin p1_point = 1'b0; p2_point = 1'b0; end
    cyc(1);
    check_model(tag);
  endtask

  task automatic run_pause;
    int base, kx;
    base = serve_count;
    kx   = $urandom_range(1, PAUSE_MS - 2);
    for (int k = 1; k <= PAUSE_MS; k++) begin
      one_tick();
      if (k == kx) pulse_ignored("pause_ignore");
      if (k == PAUSE_MS - 1) begin
        check("pause_no_serve", serve_count, base);
        check("pause_enable", ball_enable, 0);
      end
      if (k == PAUSE_MS) check("pause_serve", serve_count, base + 1);
    end
    cyc(1);
    check("pause_enable_after", ball_enable, 1);
    check("pause_serve_drop", ball_serve, 0);
  endtask

  initial begin
    cyc(3);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) one_tick();
    check_model("idle");
    check("idle_enable", ball_enable, 0);
    check("idle_serves", serve_count, 0);
    check("idle_countdown", countdown, 0);

    press_key(GS_IDLE);
    m_gs = GS_RUN;
    check("start_gs", game_state, GS_RUN);
    release_key();
    run_countdown();

    cyc($urandom_range(1, 20));
    score_point(1'b0, 1'b1);
    run_pause();
    cyc($urandom_range(1, 20));
    score_point(1'b1, 1'b1);
    run_pause();

`ifdef MATCH_PAUSE_EN
    press_key(GS_RUN);
    check("paused_enable", ball_enable, 0);
    release_key();
    s0 = serve_count;
    pulse_ignored("paused_ignore");
    press_key(GS_RUN);
    release_key();
    check("resume_enable", ball_enable, 1);
    check("resume_no_serve", serve_count, s0);
`else
    press_key(GS_RUN);
    release_key();
    check("play_press_enable", ball_enable, 1);
    check("play_press_gs", game_state, GS_RUN);
`endif

    while (m_p1 < WIN_SCORE - 1) begin
      cyc($urandom_range(1, 30));
      if ($urandom_range(0, 2) == 0 && m_p2 < WIN_SCORE - 2) score_point(1'b0, 1'b1);
      else score_point(1'b1, 1'b0);
      run_pause();
    end
    cyc($urandom_range(1, 30));
    score_point(1'b1, 1'b0);
    check("win_gs", game_state, GS_P1_WIN);
    cyc(5);
    pulse_ignored("over_frozen");
    check("over_enable", ball_enable, 0);

    press_key(GS_P1_WIN);
    m_p1 = 0; m_p2 = 0; m_gs = GS_RUN;
    check_model("restart");
    check("restart_countdown", countdown, COUNT_SECS);
    check("restart_dir", serve_dir, 0);
    release_key();

    for (int i = 0; i < 500; i++) one_tick();
    check("mid_cd", countdown, COUNT_SECS);
    s0 = serve_count;
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    m_gs = GS_IDLE;
    check_model("rst_cd");
    check("rst_cd_countdown", countdown, 0);
    for (int i = 0; i < 2600; i++) one_tick();
    check("rst_cd_no_serve", serve_count, s0);
    check("rst_cd_still_idle", game_state, GS_IDLE);

    press_key(GS_IDLE);
    m_gs = GS_RUN;
    release_key();
    run_countdown();
    score_point(1'b1, 1'b0);
    for (int i = 0; i < 300; i++) one_tick();
    s0 = serve_count;
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    m_p1 = 0; m_p2 = 0; m_gs = GS_IDLE;
    check_model("rst_pause");
    check("rst_pause_enable", ball_enable, 0);
    check("rst_pause_dir", serve_dir, 0);
    for (int i = 0; i < 800; i++) one_tick();
    check("rst_pause_no_serve", serve_count, s0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
